// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner:
//               FSM state encoding, per-scan result encoding, special key
//               codes and the row/column to hex-code key map.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_result_e;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_NEWPW = 4'hA;

  // Physical layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C,
  // row3 = 0 F E D (columns 0..3 left to right).
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Press/release debounce FSM driven by one result per full
//               keypad scan. Emits a single valid pulse per accepted press.
// Ports       : clk_i      - clock (rising edge)
//               rst_i      - synchronous active-high reset
//               scan_i     - strobe: result_i/code_i hold a full-scan result
//               result_i   - none / single / multi for the completed scan
//               code_i     - hex code of the key when result_i is single
//               valid_o    - one-cycle pulse when a press is accepted
//               digit_o    - last accepted code, held until the next accept
//               key_held_o - high in PRESSED or RELEASE_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         scan_i,
  input  scan_result_e result_i,
  input  logic [3:0]   code_i,
  output logic         valid_o,
  output logic [3:0]   digit_o,
  output logic         key_held_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             is_single;

  always_comb begin
    // Multi-key scans behave exactly like empty scans.
    is_single = (result_i == SCAN_SINGLE);
    cnt_inc   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    digit_d   = digit_q;
    valid_d   = 1'b0;
    if (scan_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_d = code_i;
            cnt_d  = CNT_ONE;
            if (CNT_ONE >= CNT_MAX) begin
              state_d = ST_PRESSED;
              digit_d = code_i;
              valid_d = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!is_single) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (code_i != cand_q) begin
            cand_d = code_i;
            cnt_d  = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state_d = ST_PRESSED;
              digit_d = cand_q;
              valid_d = 1'b1;
            end
          end
        end
        ST_PRESSED: begin
          if (!is_single) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (is_single) begin
            state_d = ST_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'h0;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o    = valid_q;
  assign digit_o    = digit_q;
  assign key_held_o = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               samples the rows at the end of each column period, classifies
//               each full scan and feeds the debounce FSM.
// Ports       : clk           - clock (rising edge)
//               reset         - synchronous active-high reset
//               keyPad_row    - active-low row sense lines
//               keyPad_column - column drive, exactly one bit low
//               digit         - last accepted key code
//               valid         - one-cycle pulse per accepted press
//               enter         - valid pulse for code 4'hE
//               newPassword   - valid pulse for code 4'hA
//               keyHeld       - a key is considered held
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] digit,
  output logic       valid,
  output logic       enter,
  output logic       newPassword,
  output logic       keyHeld
);

  localparam int              DIV_W    = $clog2(SCAN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  // Keys seen so far in the current scan: 0, 1, or 2 meaning "two or more".
  logic [1:0]       hits_q, hits_d, w_hits_acc;
  logic [3:0]       code_q, code_d;

  logic             w_sample;
  logic             w_scan_done;
  logic [3:0]       w_row_low;
  logic [2:0]       w_row_low_cnt;
  logic [1:0]       w_row_idx;
  scan_result_e     w_scan_result;

  assign w_row_low = ~keyPad_row;

  always_comb begin
    w_row_low_cnt = 3'd0;
    w_row_idx     = 2'd0;
    for (int r = 0; r < 4; r++) begin
      w_row_low_cnt = w_row_low_cnt + {2'b00, w_row_low[r]};
      if (w_row_low[r]) w_row_idx = 2'(r);
    end
  end

  always_comb begin
    w_sample    = (div_q == DIV_LAST);
    w_scan_done = w_sample && (col_q == 2'd3);
    div_d       = w_sample ? '0 : div_q + DIV_ONE;
    col_d       = w_sample ? col_q + 2'd1 : col_q;
    w_hits_acc  = hits_q;
    code_d      = code_q;
    if (w_sample) begin
      if ((w_row_low_cnt >= 3'd2) || ((w_row_low_cnt == 3'd1) && (hits_q != 2'd0))) begin
        w_hits_acc = 2'd2;
      end else if (w_row_low_cnt == 3'd1) begin
        w_hits_acc = 2'd1;
        code_d     = key_code(w_row_idx, col_q);
      end
    end
    // The result includes the column-3 sample taken on this same edge, so
    // the FSM sees the completed scan without an extra cycle of latency.
    unique case (w_hits_acc)
      2'd0:    w_scan_result = SCAN_NONE;
      2'd1:    w_scan_result = SCAN_SINGLE;
      default: w_scan_result = SCAN_MULTI;
    endcase
    hits_d = w_scan_done ? 2'd0 : w_hits_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      col_q  <= 2'd0;
      hits_q <= 2'd0;
      code_q <= 4'h0;
    end else begin
      div_q  <= div_d;
      col_q  <= col_d;
      hits_q <= hits_d;
      code_q <= code_d;
    end
  end

  assign keyPad_column = ~(4'b0001 << col_q);

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i     (clk),
    .rst_i     (reset),
    .scan_i    (w_scan_done),
    .result_i  (w_scan_result),
    .code_i    (code_d),
    .valid_o   (valid),
    .digit_o   (digit),
    .key_held_o(keyHeld)
  );

  assign enter       = valid && (digit == KEY_ENTER);
  assign newPassword = valid && (digit == KEY_NEWPW);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with a keypad model
//               and a queue of expected valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keyPad_row;
  logic [3:0] keyPad_column;
  logic [3:0] digit;
  logic       valid, enter, newPassword, keyHeld;

  // Pressed keys, bit index = row*4 + col.
  logic [15:0] pressed = 16'h0000;

  typedef struct {
    logic [3:0] digit;
    logic       enter;
    logic       newpw;
    int         edge_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   base   = 0;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keyPad_row   (keyPad_row),
    .keyPad_column(keyPad_column),
    .digit        (digit),
    .valid        (valid),
    .enter        (enter),
    .newPassword  (newPassword),
    .keyHeld      (keyHeld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a pressed key shorts its row to its column.
  always_comb begin
    keyPad_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !keyPad_column[c]) keyPad_row[r] = 1'b0;
  end

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] m;
    m = 16'h0001;
    return m << (r*4 + c);
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got pulse digit=%h at edge %0d, required no pulse", digit, cyc - base);
      end else begin
        mon_e = exp_q.pop_front();
        if (digit !== mon_e.digit || enter !== mon_e.enter || newPassword !== mon_e.newpw ||
            (cyc - base) != mon_e.edge_n) begin
          errors++;
          $display("FAIL pulse: got digit=%h enter=%b newpw=%b edge=%0d, required digit=%h enter=%b newpw=%b edge=%0d",
                   digit, enter, newPassword, cyc - base, mon_e.digit, mon_e.enter, mon_e.newpw, mon_e.edge_n);
        end
      end
    end
    if (!valid && (enter || newPassword)) begin
      errors++;
      $display("FAIL stray_flag: got enter=%b newpw=%b without valid, required 0", enter, newPassword);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [3:0] d, input int e);
    exp_q.push_back('{digit: d, enter: (d == 4'hE), newpw: (d == 4'hA), edge_n: e});
  endtask

  // Reset with the given keys held; edge numbering restarts at release.
  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    reset   = 1'b1;
    pressed = keys;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic goto_edge(input int n);
    while ((cyc - base) < n) @(negedge clk);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulse: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (keyPad_column !== 4'b1110) begin errors++; $display("FAIL reset_column: got %b, required 1110", keyPad_column); end
    checks++;
    if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h, required 0", digit); end
    checks++;
    if ({valid, enter, newPassword, keyHeld} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/enter/newpw/held=%b, required 0000", {valid, enter, newPassword, keyHeld});
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    logic [3:0] one;
    one = 4'b0001;
    do_reset(16'h0000);
    for (int k = 0; k < 48; k++) begin
      goto_edge(k);
      exp_col = ~(one << ((k / SCAN_DIV) % 4));
      checks++;
      if (keyPad_column !== exp_col) begin
        errors++;
        $display("FAIL idle_column: edge %0d got %b, required %b", k, keyPad_column, exp_col);
      end
    end
    drain_check("idle");
  endtask

  task automatic test_hold_key5();
    do_reset(kbit(1, 1));
    push_exp(4'h5, 32);
    goto_edge(31);
    checks++;
    if (keyHeld !== 1'b0) begin errors++; $display("FAIL hold5_held_early: got %b, required 0", keyHeld); end
    goto_edge(32);
    checks++;
    if (keyHeld !== 1'b1) begin errors++; $display("FAIL hold5_held_accept: got %b, required 1", keyHeld); end
    goto_edge(160);
    pressed = 16'h0000;
    goto_edge(191);
    checks++;
    if (keyHeld !== 1'b1) begin errors++; $display("FAIL hold5_held_release_wait: got %b, required 1", keyHeld); end
    goto_edge(192);
    checks++;
    if (keyHeld !== 1'b0) begin errors++; $display("FAIL hold5_held_after_release: got %b, required 0", keyHeld); end
    checks++;
    if (digit !== 4'h5) begin errors++; $display("FAIL hold5_digit_held: got %h, required 5", digit); end
    drain_check("hold5");
  endtask

  task automatic test_enter_newpw();
    do_reset(kbit(3, 2));
    push_exp(4'hE, 32);
    goto_edge(48);
    pressed = 16'h0000;
    goto_edge(96);
    pressed = kbit(0, 3);
    push_exp(4'hA, 128);
    goto_edge(144);
    pressed = 16'h0000;
    goto_edge(192);
    drain_check("enter_newpw");
  endtask

  task automatic test_bounce();
    do_reset(kbit(2, 0));
    goto_edge(16);
    pressed = 16'h0000;
    goto_edge(32);
    pressed = kbit(2, 0);
    push_exp(4'h7, 64);
    goto_edge(48);
    checks++;
    if (keyHeld !== 1'b0) begin errors++; $display("FAIL bounce_early_held: got %b, required 0", keyHeld); end
    goto_edge(80);
    pressed = 16'h0000;
    goto_edge(128);
    drain_check("bounce");
  endtask

  task automatic test_multi();
    do_reset(kbit(0, 0) | kbit(2, 2));
    goto_edge(64);
    checks++;
    if (keyHeld !== 1'b0) begin errors++; $display("FAIL multi_idle_held: got %b, required 0", keyHeld); end
    pressed = 16'h0000;
    goto_edge(96);
    pressed = kbit(0, 2);
    push_exp(4'h3, 128);
    goto_edge(144);
    pressed = kbit(0, 2) | kbit(1, 2);
    goto_edge(208);
    pressed = 16'h0000;
    goto_edge(256);
    checks++;
    if (digit !== 4'h3) begin errors++; $display("FAIL multi_digit: got %h, required 3", digit); end
    drain_check("multi");
  endtask

  task automatic test_reset_midpress();
    do_reset(kbit(3, 3));
    push_exp(4'hD, 32);
    goto_edge(40);
    checks++;
    if (keyHeld !== 1'b1) begin errors++; $display("FAIL midpress_held: got %b, required 1", keyHeld); end
    drain_check("midpress_first");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({keyPad_column, digit, valid, enter, newPassword, keyHeld} !== {4'b1110, 4'h0, 4'b0000}) begin
      errors++;
      $display("FAIL midpress_reset_outputs: got col=%b digit=%h flags=%b, required col=1110 digit=0 flags=0000",
               keyPad_column, digit, {valid, enter, newPassword, keyHeld});
    end
    reset = 1'b0;
    base  = cyc;
    push_exp(4'hD, 32);
    goto_edge(31);
    checks++;
    if (digit !== 4'h0 || keyHeld !== 1'b0) begin
      errors++;
      $display("FAIL midpress_pre_accept: got digit=%h held=%b, required digit=0 held=0", digit, keyHeld);
    end
    goto_edge(48);
    pressed = 16'h0000;
    goto_edge(112);
    drain_check("midpress_second");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_hold_key5();
    test_enter_newpw();
    test_bounce();
    test_multi();
    test_reset_midpress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
